// File: rtl/des_byte_stream_adapter.sv
// Byte-stream front/back end for the 16-round DES round controller: packs key/plaintext bytes,
// runs the start/ready handshake, streams the result out. Optional watchdog: DES_TIMEOUT_EN.
module des_byte_stream_adapter #(
    parameter int SETUP_CYCLES = 2,
    parameter int TIMEOUT      = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    input  logic        in_is_key,
    output logic        des_start,
    output logic [63:0] des_in,
    output logic [63:0] des_key,
    input  logic        des_ready,
    input  logic [63:0] des_result,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        busy,
    output logic        err
);

    localparam int SW = (SETUP_CYCLES > 2) ? $clog2(SETUP_CYCLES) : 1;

    if (SETUP_CYCLES < 2) begin : g_bad_setup
        $error("SETUP_CYCLES must be at least 2");
    end
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("TIMEOUT must fit the 8-bit watchdog (1..255)");
    end

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_SETUP   = 2'd1,
        ST_RUN     = 2'd2,
        ST_DRAIN   = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [63:0]   key_q, key_d;
    logic [63:0]   blk_q, blk_d;
    logic [63:0]   res_q, res_d;
    logic [2:0]    key_cnt_q, key_cnt_d;
    logic [2:0]    dat_cnt_q, dat_cnt_d;
    logic [2:0]    out_cnt_q, out_cnt_d;
    logic          key_loaded_q, key_loaded_d;
    logic          blk_full_q, blk_full_d;
    logic [SW-1:0] setup_cnt_q, setup_cnt_d;
    logic          launch;
    logic          in_xfer;
    logic          out_xfer;
    logic          timeout;

`ifdef DES_TIMEOUT_EN
    logic [7:0]    wdog_q, wdog_d;

    assign timeout = (state_q == ST_RUN) && (wdog_q == 8'(TIMEOUT - 1)) && !des_ready;
`else
    assign timeout = 1'b0;
`endif

    // A complete block waits for a complete key; a half-rewritten key must not be launched.
    assign launch   = blk_full_q && key_loaded_q && (key_cnt_q == 3'd0);
    // While a full block waits for its key, further data bytes are held off rather than lost.
    assign in_ready = (state_q == ST_COLLECT) && !launch && (in_is_key || !blk_full_q);
    assign in_xfer  = in_valid && in_ready;
    assign out_valid = (state_q == ST_DRAIN);
    assign out_xfer  = out_valid && out_ready;
    assign out_data  = res_q[63:56];
    assign des_start = (state_q == ST_RUN) && !timeout;
    assign des_in    = blk_q;
    assign des_key   = key_q;
    assign busy      = (state_q != ST_COLLECT);
    assign err       = timeout;

    always_comb begin
        state_d      = state_q;
        key_d        = key_q;
        blk_d        = blk_q;
        res_d        = res_q;
        key_cnt_d    = key_cnt_q;
        dat_cnt_d    = dat_cnt_q;
        out_cnt_d    = out_cnt_q;
        key_loaded_d = key_loaded_q;
        blk_full_d   = blk_full_q;
        setup_cnt_d  = setup_cnt_q;
`ifdef DES_TIMEOUT_EN
        wdog_d       = wdog_q;
`endif
        case (state_q)
            ST_COLLECT: begin
                if (in_xfer) begin
                    if (in_is_key) begin
                        key_d     = {key_q[55:0], in_data};
                        key_cnt_d = key_cnt_q + 3'd1;
                        if (key_cnt_q == 3'd7) begin
                            key_loaded_d = 1'b1;
                        end
                    end else begin
                        blk_d     = {blk_q[55:0], in_data};
                        dat_cnt_d = dat_cnt_q + 3'd1;
                        if (dat_cnt_q == 3'd7) begin
                            blk_full_d = 1'b1;
                        end
                    end
                end
                if (launch) begin
                    state_d     = ST_SETUP;
                    blk_full_d  = 1'b0;
                    setup_cnt_d = '0;
                end
            end
            ST_SETUP: begin
                if (setup_cnt_q == SW'(SETUP_CYCLES - 1)) begin
                    state_d = ST_RUN;
`ifdef DES_TIMEOUT_EN
                    wdog_d  = 8'd0;
`endif
                end else begin
                    setup_cnt_d = setup_cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (des_ready) begin
                    res_d     = des_result;
                    out_cnt_d = 3'd0;
                    state_d   = ST_DRAIN;
                end else if (timeout) begin
                    state_d = ST_COLLECT;
                end
`ifdef DES_TIMEOUT_EN
                else begin
                    wdog_d = wdog_q + 8'd1;
                end
`endif
            end
            ST_DRAIN: begin
                if (out_xfer) begin
                    res_d     = {res_q[55:0], 8'h00};
                    out_cnt_d = out_cnt_q + 3'd1;
                    if (out_cnt_q == 3'd7) begin
                        state_d = ST_COLLECT;
                    end
                end
            end
            default: state_d = ST_COLLECT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_COLLECT;
            key_q        <= '0;
            blk_q        <= '0;
            res_q        <= '0;
            key_cnt_q    <= '0;
            dat_cnt_q    <= '0;
            out_cnt_q    <= '0;
            key_loaded_q <= 1'b0;
            blk_full_q   <= 1'b0;
            setup_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            key_q        <= key_d;
            blk_q        <= blk_d;
            res_q        <= res_d;
            key_cnt_q    <= key_cnt_d;
            dat_cnt_q    <= dat_cnt_d;
            out_cnt_q    <= out_cnt_d;
            key_loaded_q <= key_loaded_d;
            blk_full_q   <= blk_full_d;
            setup_cnt_q  <= setup_cnt_d;
        end
    end

`ifdef DES_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog_q <= 8'd0;
        end else begin
            wdog_q <= wdog_d;
        end
    end
`endif

endmodule

// File: tb/tb_des_byte_stream_adapter.sv
// Directed bench for des_byte_stream_adapter with a behavioural DES controller stub.
module tb_des_byte_stream_adapter;

    localparam logic [63:0] KEY  = 64'h133457799BBCDFF1;
    localparam logic [63:0] PT   = 64'h0123456789ABCDEF;
    localparam logic [63:0] CT   = 64'h85E813540F0AB405;
    localparam logic [63:0] PT2  = 64'hFEDCBA9876543210;
    localparam logic [63:0] CT2  = 64'hEDE8EDE1EDE8EDE1;
    localparam int          TMO  = 255;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        in_is_key;
    logic        des_start;
    logic [63:0] des_in;
    logic [63:0] des_key;
    logic        des_ready;
    logic [63:0] des_result;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        busy;
    logic        err;

    int nvec = 0;
    int nerr = 0;

    logic [4:0] stub_cnt;
    logic       stub_force;
    logic       stub_hang;

    des_byte_stream_adapter #(.SETUP_CYCLES(2), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_is_key(in_is_key),
        .des_start(des_start), .des_in(des_in), .des_key(des_key),
        .des_ready(des_ready), .des_result(des_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Controller stand-in: ready 16 cycles after start; known vector maps to its real ciphertext,
    // anything else to des_in ^ des_key.
    always @(posedge clk) begin
        if (!des_start) stub_cnt <= 5'd0;
        else if (stub_cnt != 5'd31) stub_cnt <= stub_cnt + 5'd1;
    end
    assign des_ready  = stub_force || (des_start && !stub_hang && stub_cnt >= 5'd16);
    assign des_result = (des_in == PT && des_key == KEY) ? CT : (des_in ^ des_key);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic k, input logic [7:0] b);
        int n;
        n = 0;
        in_valid  = 1'b1;
        in_is_key = k;
        in_data   = b;
        #1;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 100) chk("in_accept_timeout", 64'd0, 64'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_block(input logic k, input logic [63:0] blk);
        for (int i = 0; i < 8; i++) send_byte(k, blk[63-8*i -: 8]);
    endtask

    task automatic wait_start(input string tag);
        int n;
        n = 0;
        while (!des_start && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {63'd0, des_start}, 64'd1);
    endtask

    task automatic recv_block(input logic [63:0] exp, input int stall);
        int n;
        for (int i = 0; i < 8; i++) begin
            n = 0;
            while (!out_valid && n < 200) begin
                @(negedge clk);
                n++;
            end
            chk("out_valid", {63'd0, out_valid}, 64'd1);
            chk($sformatf("out_byte%0d", i), {56'd0, out_data}, {56'd0, exp[63-8*i -: 8]});
            if (i == 0 && stall > 0) begin
                out_ready = 1'b0;
                repeat (stall) @(negedge clk);
                chk("stall_valid", {63'd0, out_valid}, 64'd1);
                chk("stall_data", {56'd0, out_data}, {56'd0, exp[63:56]});
            end
            out_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            out_ready = 1'b0;
        end
        chk("busy_after_drain", {63'd0, busy}, 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int n;
        rst = 1'b1;
        in_valid = 1'b0; in_is_key = 1'b0; in_data = 8'h00;
        out_ready = 1'b0; stub_force = 1'b0; stub_hang = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_des_start", {63'd0, des_start}, 64'd0);
        chk("rst_des_in", des_in, 64'd0);
        chk("rst_des_key", des_key, 64'd0);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_data", {56'd0, out_data}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_err", {63'd0, err}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // 1: key then data, check packing and output order
        send_block(1'b1, KEY);
        send_block(1'b0, PT);
        wait_start("t1_start");
        chk("t1_des_key", des_key, KEY);
        chk("t1_des_in", des_in, PT);
        recv_block(CT, 0);

        // 2: key retained
        send_block(1'b0, PT);
        recv_block(CT, 0);

        // 3: interleaved bytes, output stall
        for (int i = 0; i < 8; i++) begin
            send_byte(1'b1, KEY[63-8*i -: 8]);
            send_byte(1'b0, PT[63-8*i -: 8]);
        end
        recv_block(CT, 10);

        // partial key rewrite blocks launch until completed
        for (int i = 0; i < 4; i++) send_byte(1'b1, KEY[63-8*i -: 8]);
        send_block(1'b0, PT);
        repeat (8) @(negedge clk);
        chk("partial_key_busy", {63'd0, busy}, 64'd0);
        chk("partial_key_start", {63'd0, des_start}, 64'd0);
        for (int i = 4; i < 8; i++) send_byte(1'b1, KEY[63-8*i -: 8]);
        wait_start("partial_key_launch");
        recv_block(CT, 0);

        // spurious des_ready in COLLECT ignored
        stub_force = 1'b1;
        repeat (3) @(negedge clk);
        chk("spurious_out_valid", {63'd0, out_valid}, 64'd0);
        chk("spurious_busy", {63'd0, busy}, 64'd0);
        stub_force = 1'b0;

        // 5: reset while in RUN
        send_block(1'b0, PT);
        wait_start("t5_start");
        #2 rst = 1'b1;
        #1;
        chk("t5_des_start", {63'd0, des_start}, 64'd0);
        chk("t5_out_valid", {63'd0, out_valid}, 64'd0);
        chk("t5_busy", {63'd0, busy}, 64'd0);
        chk("t5_des_key", des_key, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // 4: data block before key; key was lost by reset
        send_block(1'b0, PT);
        repeat (10) @(negedge clk);
        chk("t4_no_key_busy", {63'd0, busy}, 64'd0);
        chk("t4_no_key_start", {63'd0, des_start}, 64'd0);
        send_block(1'b1, KEY);
        n = 0;
        while (!des_start && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t4_latency", 64'(n), 64'd3);
        recv_block(CT, 0);

        // second plaintext exercises byte ordering through the stub's xor path
        send_block(1'b0, PT2);
        recv_block(CT2, 0);

`ifdef DES_TIMEOUT_EN
        // 6: controller never answers
        stub_hang = 1'b1;
        send_block(1'b0, PT);
        wait_start("t6_start");
        repeat (TMO - 2) @(negedge clk);
        chk("t6_pre_start", {63'd0, des_start}, 64'd1);
        chk("t6_pre_err", {63'd0, err}, 64'd0);
        @(negedge clk);
        chk("t6_err", {63'd0, err}, 64'd1);
        chk("t6_start_low", {63'd0, des_start}, 64'd0);
        chk("t6_no_out", {63'd0, out_valid}, 64'd0);
        @(negedge clk);
        chk("t6_err_clear", {63'd0, err}, 64'd0);
        chk("t6_in_ready", {63'd0, in_ready}, 64'd1);
        chk("t6_out_valid", {63'd0, out_valid}, 64'd0);
        stub_hang = 1'b0;
        send_block(1'b0, PT);
        recv_block(CT, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
